// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and link-wide default constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned UART_OVERSAMPLE = 5;
  localparam int unsigned UART_DATA_BITS  = 8;

endpackage

// File: rtl/uart_bit_timer.sv
// Counts ENABLE ticks within one UART bit and flags the tick that ends the bit.
module uart_bit_timer #(
  parameter int unsigned OVERSAMPLE = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic bit_end_c_o
);

  localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic [TICK_W-1:0] tick_d;
  logic [TICK_W-1:0] tick_q;

  always_comb begin
    tick_d = tick_q;
    if (clr_i) begin
      tick_d = '0;
    end else if (en_i) begin
      tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_d;
    end
  end

  // Combinational so the FSM moves to the next bit on the same edge the last tick lands.
  assign bit_end_c_o = en_i & ~clr_i & (tick_q == TICK_LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, stop bit(s).
// Define UART_TX_PARITY_EN to insert the parity bit after the data bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 ENABLE,
  input  logic                 send,
  input  logic [DATA_BITS-1:0] word_transmitter,
  output logic                 TX,
  output logic                 busy,
  output logic                 priznak_end_transmitter
);

  localparam int unsigned BIT_W = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_t            state_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 end_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [BIT_W-1:0]     bit_cnt_q;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q;
`endif
  logic                 bit_end_c;

  // Timer is held clear while idle so every frame starts from tick 0.
  uart_bit_timer #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_bit_timer (
    .clk_i       (clk),
    .rst_i       (res),
    .clr_i       (state_q == IDLE),
    .en_i        (ENABLE),
    .bit_end_c_o (bit_end_c)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= IDLE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      end_q     <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (send) begin
            shift_q   <= word_transmitter;
            bit_cnt_q <= '0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= START;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^word_transmitter;
`endif
          end
        end
        START: begin
          if (bit_end_c) begin
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_cnt_q <= '0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              tx_q      <= parity_q;
              state_q   <= PARITY;
`else
              tx_q      <= 1'b1;
              state_q   <= STOP;
`endif
            end else begin
              tx_q      <= shift_q[0];
              shift_q   <= shift_q >> 1;
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end_c) begin
            tx_q      <= 1'b1;
            bit_cnt_q <= '0;
            state_q   <= STOP;
          end
        end
`endif
        STOP: begin
          // bit_cnt_q counts completed stop bits here.
          if (bit_end_c) begin
            if (bit_cnt_q == STOP_LAST) begin
              bit_cnt_q <= '0;
              busy_q    <= 1'b0;
              end_q     <= 1'b1;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign TX                      = tx_q;
  assign busy                    = busy_q;
  assign priznak_end_transmitter = end_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx (default 5x oversample, 8 data bits, 1 stop bit).
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk;
  logic       res;
  logic       ENABLE;
  logic       send;
  logic [7:0] word_transmitter;
  logic       TX;
  logic       busy;
  logic       priznak_end_transmitter;

  int checks;
  int failures;
  int gap_cnt;
  int phase;
  logic div;

  uart_tx #(
    .OVERSAMPLE (5),
    .DATA_BITS  (8),
    .STOP_BITS  (1)
  ) dut (
    .clk                     (clk),
    .res                     (res),
    .ENABLE                  (ENABLE),
    .send                    (send),
    .word_transmitter        (word_transmitter),
    .TX                      (TX),
    .busy                    (busy),
    .priznak_end_transmitter (priznak_end_transmitter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: sample point is 1 time unit after the edge; ENABLE for the next edge is set here.
  task automatic step();
    @(posedge clk);
    #1;
    if (gap_cnt > 0) gap_cnt--;
    else if (div) phase = (phase + 1) % 3;
    if (gap_cnt > 0) ENABLE = 1'b0;
    else ENABLE = div ? (phase == 0) : 1'b1;
  endtask

  task automatic idle_chk(input string tag);
    chk($sformatf("%s_tx", tag), TX, 1'b1);
    chk($sformatf("%s_busy", tag), busy, 1'b0);
    chk($sformatf("%s_pulse", tag), priznak_end_transmitter, 1'b0);
  endtask

  // Called at the sample point just after the acceptance edge; returns at the end-pulse sample.
  task automatic check_frame(input string tag, input logic [7:0] w, input logic par,
                             input int cpb, input int gap_idx);
    logic seq [0:11];
    int   nb;
    int   dur;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[i+1] = w[i];
    seq[9] = par;
    nb = 9 + P;
    seq[nb] = 1'b1;
    nb++;
    for (int b = 0; b < nb; b++) begin
      dur = cpb + ((b == gap_idx) ? 40 : 0);
      for (int k = 0; k < dur; k++) begin
        if (b == gap_idx && k == 7) begin
          gap_cnt = 40;
          ENABLE  = 1'b0;
        end
        chk($sformatf("%s_tx_b%0d_k%0d", tag, b, k), TX, seq[b]);
        chk($sformatf("%s_busy_b%0d_k%0d", tag, b, k), busy, 1'b1);
        chk($sformatf("%s_pulse_b%0d_k%0d", tag, b, k), priznak_end_transmitter, 1'b0);
        step();
      end
    end
    chk($sformatf("%s_end_tx", tag), TX, 1'b1);
    chk($sformatf("%s_end_busy", tag), busy, 1'b0);
    chk($sformatf("%s_end_pulse", tag), priznak_end_transmitter, 1'b1);
  endtask

  initial begin
    checks           = 0;
    failures         = 0;
    gap_cnt          = 0;
    phase            = 0;
    div              = 1'b0;
    res              = 1'b1;
    ENABLE           = 1'b1;
    send             = 1'b0;
    word_transmitter = 8'h00;

    // Reset held, then a quiet idle line.
    for (int i = 0; i < 3; i++) begin
      step();
      idle_chk($sformatf("rst%0d", i));
    end
    res = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      idle_chk($sformatf("idle%0d", i));
    end

    // 0xA5 with ENABLE always high: 5 clk per bit, pulse at E0+50.
    word_transmitter = 8'hA5;
    send = 1'b1;
    step();
    send = 1'b0;
    check_frame("a5", 8'hA5, 1'b0, 5, -1);
    step();
    idle_chk("a5_after");

    // ENABLE every third clock: 15 clk per bit.
    div = 1'b1;
    phase = 0;
    ENABLE = 1'b1;
    send = 1'b1;
    step();
    send = 1'b0;
    check_frame("div3", 8'hA5, 1'b0, 15, -1);
    step();
    idle_chk("div3_after");

    // Same, with a 40-clk ENABLE gap inside data bit 3.
    phase = 0;
    ENABLE = 1'b1;
    send = 1'b1;
    step();
    send = 1'b0;
    check_frame("gap", 8'hA5, 1'b0, 15, 4);
    step();
    idle_chk("gap_after");
    div = 1'b0;
    ENABLE = 1'b1;

    // send held high: 0x00 then 0xFF back to back, word changed while each frame is in flight.
    word_transmitter = 8'h00;
    send = 1'b1;
    step();
    word_transmitter = 8'hFF;
    check_frame("b2b0", 8'h00, 1'b0, 5, -1);
    step();
    word_transmitter = 8'h00;
    check_frame("b2b1", 8'hFF, 1'b0, 5, -1);
    send = 1'b0;
    step();
    idle_chk("b2b_after");

    // Reset in the middle of data bit 3, then a clean frame.
    word_transmitter = 8'hA5;
    send = 1'b1;
    step();
    send = 1'b0;
    for (int i = 0; i < 23; i++) step();
    chk("midrst_pre_tx", TX, 1'b0);
    chk("midrst_pre_busy", busy, 1'b1);
    res = 1'b1;
    step();
    idle_chk("midrst");
    res = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      idle_chk($sformatf("midrst_quiet%0d", i));
    end
    send = 1'b1;
    step();
    send = 1'b0;
    check_frame("post_rst", 8'hA5, 1'b0, 5, -1);
    step();
    idle_chk("post_rst_after");

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones, so even parity is 1.
    word_transmitter = 8'h07;
    send = 1'b1;
    step();
    send = 1'b0;
    check_frame("par07", 8'h07, 1'b1, 5, -1);
    step();
    idle_chk("par07_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter: the transmit end of the team's oversampled UART link, feeding the line sampled by our receiver. Accepts an 8-bit word on a request, shifts out start bit, data LSB-first, optional parity and stop bit(s). Each bit is held for OVERSAMPLE pulses of the shared ENABLE sample tick, matching the receiver's 5-sample majority vote. Signals frame completion with a one-clock pulse that the receiver uses to clear its connect flag.

## Interface
- OVERSAMPLE, 5: ENABLE ticks per bit; legal range 2..16.
- DATA_BITS, 8: data bits per frame; legal range 5..8.
- STOP_BITS, 1: stop bits per frame; 1 or 2.
- clk  in  1  system clock; all logic on posedge.
- res  in  1  reset, synchronous, active-high.
- ENABLE  in  1  sample tick, one clk wide; advances bit timing only when 1.
- send  in  1  transmit request, level-sampled in IDLE.
- word_transmitter  in  DATA_BITS  word to send; latched on acceptance.
- TX  out  1  serial line; idle/mark = 1.
- busy  out  1  frame in progress.
- priznak_end_transmitter  out  1  one-clk pulse at frame end.

## Operation
- Reset values: TX=1, busy=0, priznak_end_transmitter=0, state IDLE, counters 0, shift register 0.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: TX=1. On an edge with send=1: latch word_transmitter, enter START, TX=0, busy=1, tick_cnt=0. ENABLE is not required for acceptance.
- Bit timing: tick_cnt counts ENABLE pulses 0..OVERSAMPLE-1. On an edge with ENABLE=1 and tick_cnt=OVERSAMPLE-1, the bit ends: tick_cnt=0 and the next bit value is driven from that edge.
- START ends -> DATA, TX=bit0. DATA sends bit_cnt 0..DATA_BITS-1, shifting right, LSB first. After the last data bit -> PARITY if enabled, else STOP. STOP drives TX=1 for STOP_BITS*OVERSAMPLE ticks.
- End of STOP: state IDLE, busy=0, priznak_end_transmitter=1 for exactly that one clk.
- send=1 while busy: ignored. word_transmitter changes while busy: ignored.
- ENABLE=0 for any duration mid-frame: the frame freezes, TX holds, and no counter moves.
- send held high continuously: back-to-back frames separated by exactly one clk of IDLE (the pulse cycle), with TX=1 in that cycle.
- res=1 mid-frame: next edge forces reset values (TX=1). No end pulse is produced, and the partial frame is abandoned.
- Arithmetic: tick_cnt width $clog2(OVERSAMPLE); bit_cnt width $clog2(DATA_BITS+1). Comparisons are unsigned and no wrap occurs beyond terminal counts.

## Timing
- Acceptance edge E0: TX=0 and busy=1 are visible after E0, so start latency is 1 clk.
- Frame length: (1+DATA_BITS+P+STOP_BITS)*OVERSAMPLE ENABLE ticks, where P=1 with parity and 0 without. Defaults give 50 ticks, or 55 with parity.
- With ENABLE tied to 1: E0+50 clk sets busy=0 and pulse=1, and the pulse clears at E0+51.
- All outputs are registered; TX has no combinational path from inputs.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after data. TX = XOR of the latched data bits (even parity), held OVERSAMPLE ticks.
- UART_TX_PARITY_EN undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

## Structure
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - default constants UART_OVERSAMPLE=5 and UART_DATA_BITS=8, shared with the receiver side.
- Sub-module uart_bit_timer: counts ENABLE ticks and outputs a one-clk bit_end strobe. It has a clear input driven on acceptance and reset.
- The FSM, shift register and bit counter stay in uart_tx.

## Test plan
- Reset then idle (res=1 for 3 clk, then send=0 for 20 clk) -> TX=1, busy=0, pulse=0 throughout.
- word_transmitter=8'hA5, send for 1 clk, ENABLE=1 always -> TX per 5-clk bit: 0,1,0,1,0,0,1,0,1,1. Pulse is exactly 1 clk at E0+50.
- Same frame with ENABLE=1 every 3rd clk -> each bit lasts 15 clk and the pulse lands at E0+150. A 40-clk ENABLE=0 gap inserted in bit 3 stretches only that bit.
- send held high with words 8'h00 then 8'hFF -> two frames, one IDLE clk between. A word change mid-frame does not alter the frame in flight.
- res=1 asserted at E0+23 (mid bit 3) -> TX=1 and busy=0 on the next edge, and no pulse is produced. A send after release starts a clean frame.
- UART_TX_PARITY_EN defined: 8'hA5 gives parity bit 0 and 8'h07 gives parity bit 1. Frame length is 55 ticks.
